// File: rtl/lcd_byte_writer_pkg.sv
// rtl/lcd_byte_writer_pkg.sv - shared FSM states, LCD command constants and init helpers
package lcd_byte_writer_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_NIB,
        INIT_WAIT,
        CFG,
        IDLE,
        SETUP_HI,
        PULSE_HI,
        GAP,
        SETUP_LO,
        PULSE_LO,
        WAIT
    } lcdState_t;

    localparam logic [7:0] FUNC_SET_4BIT = 8'h28;
    localparam logic [7:0] ENTRY_MODE    = 8'h06;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] HOME          = 8'h02;

    // Three "wake" nibbles force 8-bit mode from any state, the fourth switches to 4-bit.
    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    function automatic logic [3:0] initNibble(input logic [1:0] step);
        return (step == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    function automatic logic [7:0] cfgByte(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET_4BIT;
            2'd1:    return ENTRY_MODE;
            2'd2:    return DISP_ON;
            default: return CLEAR;
        endcase
    endfunction

    // Clear and home need the long execution wait; everything else is a normal command/char.
    function automatic logic isSlowCmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == CLEAR) || (b == HOME));
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The counter only ever holds N-1, so clog2(N) bits suffice.
    function automatic int counterWidth(input int maxCycles);
        return (maxCycles < 2) ? 1 : $clog2(maxCycles);
    endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// rtl/lcd_byte_writer_if.sv - byte input handshake plus LCD pin bundle
// master: byte producer (drives iData/iRS/iValid, sees status and pins)
// slave:  lcd_byte_writer (accepts bytes, drives oReady/oInitDone and the LCD pins)
interface lcd_byte_writer_if;
    logic [7:0] iData;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic       oInitDone;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;

    modport master (
        output iData, iRS, iValid,
        input  oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );

    modport slave (
        input  iData, iRS, iValid,
        output oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );
endinterface

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable down-counter shared by every timed LCD state
// Clock/Reset: system clock, async active-low reset (clears count)
// iLoad/iValue: load N-1 on state entry; oDone: count has reached zero
module lcd_delay_counter #(
    parameter int WIDTH = 20
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iValue,
    output logic             oDone
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (iLoad) begin
            count <= iValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign oDone = (count == '0);
endmodule

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - HD44780 4-bit writer: power-on init, then two-nibble byte writes
// Clock/Reset: system clock, async active-low reset (aborts any transfer, reruns init)
// bus (slave): iData/iRS/iValid byte strobe, oReady/oInitDone status, oLCD_E/RS/RW/D pins
module lcd_byte_writer
    import lcd_byte_writer_pkg::*;
#(
    parameter int T_PWRON  = 750000,
    parameter int T_INIT1  = 205000,
    parameter int T_INIT2  = 5000,
    parameter int T_SETUP  = 2,
    parameter int T_E_HIGH = 12,
    parameter int T_GAP    = 50,
    parameter int T_CMD    = 2000,
    parameter int T_CLEAR  = 82000
) (
    input  logic             Clock,
    input  logic             Reset,
    lcd_byte_writer_if.slave bus
);
    localparam int MAX_DELAY = maxOf(maxOf(maxOf(T_PWRON, T_INIT1), maxOf(T_INIT2, T_CMD)),
                                     maxOf(maxOf(T_CLEAR, T_GAP), maxOf(T_SETUP, T_E_HIGH)));
    localparam int CW = counterWidth(MAX_DELAY);

    lcdState_t   state, nextState;
    logic        armed, nextArmed;
    logic        pulsePhase, nextPulse;
    logic [1:0]  initStep, nextStep;
    logic [1:0]  cfgIdx, nextCfg;
    logic        initDone, nextInitDone;
    logic [7:0]  byteReg, nextByte;
    logic        byteRs, nextByteRs;
    logic [3:0]  lcdD, nextD;
    logic        lcdRs, nextRs;
    logic        cntLoad, cntDone;
    logic [CW-1:0] cntValue;
    logic [7:0]  cfgSel;
    logic [3:0]  nibNext;

    function automatic logic [CW-1:0] dly(input int n);
        return CW'(n - 1);
    endfunction

    function automatic int initWait(input logic [1:0] step);
        case (step)
            2'd0:    return T_INIT1;
            2'd1:    return T_INIT2;
            default: return T_CMD;
        endcase
    endfunction

    lcd_delay_counter #(.WIDTH(CW)) u_delay (
        .Clock  (Clock),
        .Reset  (Reset),
        .iLoad  (cntLoad),
        .iValue (cntValue),
        .oDone  (cntDone)
    );

    assign cfgSel  = cfgByte(cfgIdx);
    assign nibNext = initNibble(initStep + 2'd1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= PWR_WAIT;
            armed      <= 1'b0;
            pulsePhase <= 1'b0;
            initStep   <= 2'd0;
            cfgIdx     <= 2'd0;
            initDone   <= 1'b0;
            byteReg    <= 8'h00;
            byteRs     <= 1'b0;
            lcdD       <= 4'h0;
            lcdRs      <= 1'b0;
        end else begin
            state      <= nextState;
            armed      <= nextArmed;
            pulsePhase <= nextPulse;
            initStep   <= nextStep;
            cfgIdx     <= nextCfg;
            initDone   <= nextInitDone;
            byteReg    <= nextByte;
            byteRs     <= nextByteRs;
            lcdD       <= nextD;
            lcdRs      <= nextRs;
        end
    end

    // D/RS only change on the edge that enters a setup phase, so E (decoded from
    // state) can never rise in the same cycle as a data change.
    always_comb begin
        nextState    = state;
        nextArmed    = armed;
        nextPulse    = pulsePhase;
        nextStep     = initStep;
        nextCfg      = cfgIdx;
        nextInitDone = initDone;
        nextByte     = byteReg;
        nextByteRs   = byteRs;
        nextD        = lcdD;
        nextRs       = lcdRs;
        cntLoad      = 1'b0;
        cntValue     = '0;
        unique case (state)
            PWR_WAIT: begin
                // Counter comes out of reset at zero; the first edge arms the power-on wait.
                if (!armed) begin
                    nextArmed = 1'b1;
                    cntLoad   = 1'b1;
                    cntValue  = dly(T_PWRON);
                end else if (cntDone) begin
                    nextState = INIT_NIB;
                    nextPulse = 1'b0;
                    nextStep  = 2'd0;
                    nextD     = INIT_NIB_WAKE;
                    nextRs    = 1'b0;
                    cntLoad   = 1'b1;
                    cntValue  = dly(T_SETUP);
                end
            end
            INIT_NIB: begin
                // Setup half then enable half, distinguished by pulsePhase.
                if (cntDone) begin
                    cntLoad = 1'b1;
                    if (!pulsePhase) begin
                        nextPulse = 1'b1;
                        cntValue  = dly(T_E_HIGH);
                    end else begin
                        nextPulse = 1'b0;
                        nextState = INIT_WAIT;
                        cntValue  = dly(initWait(initStep));
                    end
                end
            end
            INIT_WAIT: begin
                if (cntDone) begin
                    cntLoad = 1'b1;
                    if (initStep == 2'd3) begin
                        nextState = CFG;
                        nextCfg   = 2'd0;
                        cntValue  = dly(1);
                    end else begin
                        nextState = INIT_NIB;
                        nextStep  = initStep + 2'd1;
                        nextD     = nibNext;
                        cntValue  = dly(T_SETUP);
                    end
                end
            end
            CFG: begin
                nextState  = SETUP_HI;
                nextByte   = cfgSel;
                nextByteRs = 1'b0;
                nextD      = cfgSel[7:4];
                nextRs     = 1'b0;
                cntLoad    = 1'b1;
                cntValue   = dly(T_SETUP);
            end
            IDLE: begin
                if (bus.iValid && initDone) begin
                    nextState  = SETUP_HI;
                    nextByte   = bus.iData;
                    nextByteRs = bus.iRS;
                    nextD      = bus.iData[7:4];
                    nextRs     = bus.iRS;
                    cntLoad    = 1'b1;
                    cntValue   = dly(T_SETUP);
                end
            end
            SETUP_HI: if (cntDone) begin
                nextState = PULSE_HI;
                cntLoad   = 1'b1;
                cntValue  = dly(T_E_HIGH);
            end
            PULSE_HI: if (cntDone) begin
                nextState = GAP;
                cntLoad   = 1'b1;
                cntValue  = dly(T_GAP);
            end
            GAP: if (cntDone) begin
                nextState = SETUP_LO;
                nextD     = byteReg[3:0];
                cntLoad   = 1'b1;
                cntValue  = dly(T_SETUP);
            end
            SETUP_LO: if (cntDone) begin
                nextState = PULSE_LO;
                cntLoad   = 1'b1;
                cntValue  = dly(T_E_HIGH);
            end
            PULSE_LO: if (cntDone) begin
                nextState = WAIT;
                cntLoad   = 1'b1;
                cntValue  = isSlowCmd(byteRs, byteReg) ? dly(T_CLEAR) : dly(T_CMD);
            end
            WAIT: begin
                if (cntDone) begin
                    if (initDone) begin
                        nextState = IDLE;
                    end else if (cfgIdx == 2'd3) begin
                        nextState    = IDLE;
                        nextInitDone = 1'b1;
                    end else begin
                        nextState = CFG;
                        nextCfg   = cfgIdx + 2'd1;
                        cntLoad   = 1'b1;
                        cntValue  = dly(1);
                    end
                end
            end
            default: nextState = PWR_WAIT;
        endcase
    end

    assign bus.oLCD_E    = (state == PULSE_HI) || (state == PULSE_LO) ||
                           ((state == INIT_NIB) && pulsePhase);
    assign bus.oLCD_RS   = lcdRs;
    assign bus.oLCD_D    = lcdD;
    assign bus.oLCD_RW   = 1'b0;
    assign bus.oReady    = (state == IDLE) && initDone;
    assign bus.oInitDone = initDone;
endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb/tb_lcd_byte_writer.sv - self-checking bench for lcd_byte_writer with a per-cycle waveform model
module tb_lcd_byte_writer;
    localparam int T_PWRON  = 100;
    localparam int T_INIT1  = 30;
    localparam int T_INIT2  = 10;
    localparam int T_SETUP  = 2;
    localparam int T_E_HIGH = 4;
    localparam int T_GAP    = 8;
    localparam int T_CMD    = 20;
    localparam int T_CLEAR  = 40;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [3:0] d;
        logic       rdy;
        logic       done;
    } expCycle_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    lcd_byte_writer_if bus();

    lcd_byte_writer #(
        .T_PWRON(T_PWRON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
        .T_E_HIGH(T_E_HIGH), .T_GAP(T_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    expCycle_t  expQ[$];
    logic       lastRs = 1'b0;
    logic [3:0] lastD = 4'h0;
    bit         inReset = 1'b1;
    bit         relReq = 1'b0;
    bit         sendReq = 1'b0;
    logic [7:0] sendData = 8'h00;
    logic       sendRs = 1'b0;
    bit         accepted = 1'b0;
    int         relTick = 0;
    int         lastFall = 0;
    bit         prevE = 1'b0;
    int         ePulses = 0;
    logic [3:0] riseD[$];
    expCycle_t  lastAct;

    task automatic checkEq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int riseAt(input int i);
        return (i < riseD.size()) ? int'(riseD[i]) : -1;
    endfunction

    task automatic pushSeg(input int n, input logic e, input logic rs, input logic [3:0] d,
                           input logic rdy, input logic done);
        expCycle_t c;
        c = {e, rs, d, rdy, done};
        for (int i = 0; i < n; i++) expQ.push_back(c);
        lastRs = rs;
        lastD  = d;
    endtask

    // One byte as the LCD sees it: two nibble writes, then the execution wait.
    task automatic pushByte(input logic rs, input logic [7:0] b, input logic dn);
        int w;
        logic [3:0] hi, lo;
        hi = b[7:4];
        lo = b[3:0];
        w  = (!rs && (b == 8'h01 || b == 8'h02)) ? T_CLEAR : T_CMD;
        pushSeg(T_SETUP,  1'b0, rs, hi, 1'b0, dn);
        pushSeg(T_E_HIGH, 1'b1, rs, hi, 1'b0, dn);
        pushSeg(T_GAP,    1'b0, rs, hi, 1'b0, dn);
        pushSeg(T_SETUP,  1'b0, rs, lo, 1'b0, dn);
        pushSeg(T_E_HIGH, 1'b1, rs, lo, 1'b0, dn);
        pushSeg(w,        1'b0, rs, lo, 1'b0, dn);
    endtask

    // Power-on wait, four raw nibbles, then the config bytes each preceded by one dispatch cycle.
    task automatic pushInit();
        logic [3:0] nib[4];
        int         wt[4];
        logic [7:0] cfg[4];
        nib = '{4'h3, 4'h3, 4'h3, 4'h2};
        wt  = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
        cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
        lastRs = 1'b0;
        lastD  = 4'h0;
        pushSeg(T_PWRON, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pushSeg(T_SETUP,  1'b0, 1'b0, nib[i], 1'b0, 1'b0);
            pushSeg(T_E_HIGH, 1'b1, 1'b0, nib[i], 1'b0, 1'b0);
            pushSeg(wt[i],    1'b0, 1'b0, nib[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            pushSeg(1, 1'b0, lastRs, lastD, 1'b0, 1'b0);
            pushByte(1'b0, cfg[i], 1'b0);
        end
    endtask

    // One clock cycle: compare outputs against the model, then drive the next edge's inputs.
    task automatic tick(input logic v, input logic [7:0] dat, input logic rs);
        expCycle_t x, a;
        @(negedge Clock);
        cyc++;
        if (inReset)               x = '0;
        else if (expQ.size() > 0)  x = expQ.pop_front();
        else                       x = {1'b0, lastRs, lastD, 1'b1, 1'b1};
        a = {bus.oLCD_E, bus.oLCD_RS, bus.oLCD_D, bus.oReady, bus.oInitDone};
        checks++;
        if (a !== x || bus.oLCD_RW !== 1'b0) begin
            errors++;
            $display("FAIL cycle %0d outputs: got E=%b RS=%b D=%h rdy=%b done=%b RW=%b, required E=%b RS=%b D=%h rdy=%b done=%b RW=0",
                     cyc, a.e, a.rs, a.d, a.rdy, a.done, bus.oLCD_RW, x.e, x.rs, x.d, x.rdy, x.done);
        end
        lastAct = a;
        if (a.e && !prevE) begin
            ePulses++;
            riseD.push_back(a.d);
        end
        if (!a.e && prevE) lastFall = cyc;
        prevE = a.e;
        if (relReq) begin
            Reset   = 1'b1;
            inReset = 1'b0;
            relReq  = 1'b0;
            relTick = cyc;
            ePulses = 0;
            riseD.delete();
            pushInit();
        end
        accepted = 1'b0;
        if (sendReq && x.rdy && !inReset) begin
            v       = 1'b1;
            dat     = sendData;
            rs      = sendRs;
            sendReq = 1'b0;
        end
        bus.iValid = v;
        bus.iData  = dat;
        bus.iRS    = rs;
        if (v && x.rdy && !inReset) begin
            pushByte(rs, dat, 1'b1);
            accepted = 1'b1;
        end
    endtask

    // Present a byte in the first cycle the writer is ready.
    task automatic send(input logic [7:0] d, input logic rs);
        int n;
        n = 0;
        sendReq  = 1'b1;
        sendData = d;
        sendRs   = rs;
        do begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end while (!accepted && n < 1000);
        sendReq = 1'b0;
    endtask

    task automatic busyCount(output int n);
        n = 0;
        do begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end while (!lastAct.rdy && n < 300);
        n = n - 1;
    endtask

    task automatic runInit();
        int n;
        logic [3:0] want[12];
        want = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        n = 0;
        do begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end while (!lastAct.done && n < 3000);
        checkEq("init length to oInitDone", cyc - relTick, 389);
        checkEq("init E pulse count", ePulses, 12);
        for (int i = 0; i < 12; i++)
            checkEq($sformatf("init pulse %0d D", i), riseAt(i), int'(want[i]));
        checkEq("oInitDone after last E fall", cyc - lastFall, 40);
        checkEq("oReady with oInitDone", int'(lastAct.rdy), 1);
    endtask

    initial begin
        int n;
        bus.iValid = 1'b0;
        bus.iData  = 8'h00;
        bus.iRS    = 1'b0;

        repeat (3) tick(1'b0, 8'h00, 1'b0);
        relReq = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        runInit();

        ePulses = 0; riseD.delete();
        send(8'h41, 1'b1);
        busyCount(n);
        checkEq("busy 0x41 RS=1", n, 40);
        checkEq("0x41 pulse count", ePulses, 2);
        checkEq("0x41 high nibble", riseAt(0), 4);
        checkEq("0x41 low nibble", riseAt(1), 1);

        send(8'h01, 1'b0);
        busyCount(n);
        checkEq("busy clear command", n, 60);
        send(8'h01, 1'b1);
        busyCount(n);
        checkEq("busy 0x01 as data", n, 40);

        ePulses = 0; riseD.delete();
        send(8'h3C, 1'b1);
        repeat (4) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h55, 1'b0);
        busyCount(n);
        checkEq("pulses with dropped strobe", ePulses, 2);
        checkEq("dropped strobe hi nibble", riseAt(0), 3);
        checkEq("dropped strobe lo nibble", riseAt(1), 12);

        for (int k = 0; k < 5; k++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            n = 0;
            do begin
                tick(1'b0, 8'h00, 1'b0);
                n++;
            end while (!lastAct.e && n < 50);
            checkEq("E rise after accept", n, T_SETUP + 1);
        end

        send(8'h48, 1'b1);
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        checkEq("E high before reset", int'(lastAct.e), 1);
        #2;
        Reset   = 1'b0;
        inReset = 1'b1;
        expQ.delete();
        lastRs = 1'b0;
        lastD  = 4'h0;
        #1;
        checkEq("reset drops E", int'(bus.oLCD_E), 0);
        checkEq("reset drops RS", int'(bus.oLCD_RS), 0);
        checkEq("reset clears D", int'(bus.oLCD_D), 0);
        checkEq("reset drops oReady", int'(bus.oReady), 0);
        checkEq("reset drops oInitDone", int'(bus.oInitDone), 0);
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        relReq = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        runInit();

        repeat (1500) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
            tick(1'($urandom_range(0, 3) == 0), d, 1'($urandom_range(0, 1)));
        end
        busyCount(n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
